// File: rtl/adam_axil_pause_ctrl_if.sv
// AXI-Lite bus bundle (AW/W/B/AR/R) used on both sides of the pause controller.
interface adam_axil_pause_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [2:0]            aw_prot;
  logic                  aw_valid;
  logic                  aw_ready;

  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_WIDTH-1:0] w_strb;
  logic                  w_valid;
  logic                  w_ready;

  logic [1:0]            b_resp;
  logic                  b_valid;
  logic                  b_ready;

  logic [ADDR_WIDTH-1:0] ar_addr;
  logic [2:0]            ar_prot;
  logic                  ar_valid;
  logic                  ar_ready;

  logic [DATA_WIDTH-1:0] r_data;
  logic [1:0]            r_resp;
  logic                  r_valid;
  logic                  r_ready;

  modport master (
    output aw_addr, aw_prot, aw_valid, input aw_ready,
    output w_data, w_strb, w_valid,    input w_ready,
    input  b_resp, b_valid,            output b_ready,
    output ar_addr, ar_prot, ar_valid, input ar_ready,
    input  r_data, r_resp, r_valid,    output r_ready
  );

  modport slave (
    input  aw_addr, aw_prot, aw_valid, output aw_ready,
    input  w_data, w_strb, w_valid,    output w_ready,
    output b_resp, b_valid,            input b_ready,
    input  ar_addr, ar_prot, ar_valid, output ar_ready,
    output r_data, r_resp, r_valid,    input r_ready
  );
endinterface

// File: rtl/adam_axil_pause_ctrl.sv
// Pause controller for one AXI-Lite path: zero-latency pass-through that, on a
// pause request, closes the request channels, drains outstanding transactions
// and then acknowledges. Releasing the request resumes pass-through.
module adam_axil_pause_ctrl #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_TRANS  = 7
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   pause_req_i,
  output logic                   pause_ack_o,
  adam_axil_pause_ctrl_if.slave  slv,
  adam_axil_pause_ctrl_if.master mst
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned CW         = $clog2(MAX_TRANS + 1);
  localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_TRANS);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_PAUSED} state_e;

  state_e        state_q, state_d;
  logic          ack_q, ack_d;
  logic [CW-1:0] aw_out_q, aw_out_d;
  logic [CW-1:0] w_out_q,  w_out_d;
  logic [CW-1:0] ar_out_q, ar_out_d;

  logic allow_aw, allow_w, allow_ar;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, any_hs, all_idle;

  logic [ADDR_WIDTH-1:0] aw_addr, ar_addr;
  logic [DATA_WIDTH-1:0] w_data, r_data;
  logic [STRB_WIDTH-1:0] w_strb;

  // Payloads pass straight through
  assign aw_addr     = slv.aw_addr;
  assign mst.aw_addr = aw_addr;
  assign mst.aw_prot = slv.aw_prot;
  assign ar_addr     = slv.ar_addr;
  assign mst.ar_addr = ar_addr;
  assign mst.ar_prot = slv.ar_prot;
  assign w_data      = slv.w_data;
  assign mst.w_data  = w_data;
  assign w_strb      = slv.w_strb;
  assign mst.w_strb  = w_strb;
  assign r_data      = mst.r_data;
  assign slv.r_data  = r_data;
  assign slv.r_resp  = mst.r_resp;
  assign slv.b_resp  = mst.b_resp;

  // Response channels are never gated
  assign slv.b_valid = mst.b_valid;
  assign mst.b_ready = slv.b_ready;
  assign slv.r_valid = mst.r_valid;
  assign mst.r_ready = slv.r_ready;

  // Request channels are gated in both directions, so a valid held upstream
  // stays pending (never withdrawn) while the gate is closed
  assign mst.aw_valid = slv.aw_valid & allow_aw;
  assign slv.aw_ready = mst.aw_ready & allow_aw;
  assign mst.w_valid  = slv.w_valid  & allow_w;
  assign slv.w_ready  = mst.w_ready  & allow_w;
  assign mst.ar_valid = slv.ar_valid & allow_ar;
  assign slv.ar_ready = mst.ar_ready & allow_ar;

  assign aw_hs    = slv.aw_valid & mst.aw_ready & allow_aw;
  assign w_hs     = slv.w_valid  & mst.w_ready  & allow_w;
  assign ar_hs    = slv.ar_valid & mst.ar_ready & allow_ar;
  assign b_hs     = mst.b_valid  & slv.b_ready;
  assign r_hs     = mst.r_valid  & slv.r_ready;
  assign any_hs   = aw_hs | w_hs | ar_hs | b_hs | r_hs;
  assign all_idle = (aw_out_q == '0) && (w_out_q == '0) && (ar_out_q == '0);

  assign pause_ack_o = ack_q;

  // Outstanding counter step: +1/-1 cancel, decrement saturates at zero
  function automatic logic [CW-1:0] cnt_step(input logic [CW-1:0] cnt,
                                             input logic inc, input logic dec);
    logic [CW-1:0] nxt;
    nxt = cnt;
    if (inc && !dec) begin
      nxt = cnt + CW'(1);
    end else if (dec && !inc && (cnt != '0)) begin
      nxt = cnt - CW'(1);
    end
    return nxt;
  endfunction

  // Channel gates decoded from the current state; all closed during reset
  always_comb begin
    allow_aw = 1'b0;
    allow_w  = 1'b0;
    allow_ar = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        allow_aw = aw_out_q < MAX_CNT;
        allow_w  = w_out_q  < MAX_CNT;
        allow_ar = ar_out_q < MAX_CNT;
      end
      ST_DRAIN: begin
        // only let through the half of a write whose partner already went
        allow_aw = w_out_q  > aw_out_q;
        allow_w  = aw_out_q > w_out_q;
      end
      default: ;
    endcase
    if (rst_i) begin
      allow_aw = 1'b0;
      allow_w  = 1'b0;
      allow_ar = 1'b0;
    end
  end

  // Next-state and registered acknowledge
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN: begin
        if (pause_req_i) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!pause_req_i)              state_d = ST_RUN;
        else if (all_idle && !any_hs)  state_d = ST_PAUSED;
      end
      ST_PAUSED: begin
        if (!pause_req_i) state_d = ST_RUN;
      end
      default: state_d = ST_PAUSED;
    endcase
    ack_d = (state_d == ST_PAUSED);
  end

  // Outstanding-transaction counters
  always_comb begin
    aw_out_d = cnt_step(aw_out_q, aw_hs, b_hs);
    w_out_d  = cnt_step(w_out_q,  w_hs,  b_hs);
    ar_out_d = cnt_step(ar_out_q, ar_hs, r_hs);
  end

  // State, acknowledge and counter registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_PAUSED;
      ack_q    <= 1'b1;
      aw_out_q <= '0;
      w_out_q  <= '0;
      ar_out_q <= '0;
    end else begin
      state_q  <= state_d;
      ack_q    <= ack_d;
      aw_out_q <= aw_out_d;
      w_out_q  <= w_out_d;
      ar_out_q <= ar_out_d;
    end
  end
endmodule
